// File: rtl/enc_dec_apb_initiator.sv
// APB initiator for the encoder/decoder register block: accepts one job, writes
// DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL, and returns the captured result.
`timescale 1ns/1ps
module enc_dec_apb_initiator #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_ctrl,
    input  logic [DATA_WIDTH-1:0]      job_data,
    input  logic [1:0]                 job_width,
    input  logic [DATA_WIDTH-1:0]      job_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_errors,
    output logic                       res_timeout,
    output logic                       busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [1:0]                r_idx;
    logic [1:0]                w_next_idx;
    logic [CNT_W-1:0]          r_cnt;
    logic [1:0]                r_ctrl;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_width;
    logic [DATA_WIDTH-1:0]     r_noise;
    logic                      w_timeout_hit;
    logic [AMBA_ADDR_WIDTH-1:0] w_paddr;
    logic [AMBA_WORD-1:0]      w_wdata;

    assign job_ready     = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_next_idx;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        case (r_state)
            IDLE: begin
                if (job_valid) begin
                    w_next     = SETUP;
                    w_next_idx = 2'd1;
                end
            end
            SETUP:  w_next = ACCESS;
            ACCESS: begin
                // Index wraps 1,2,3 -> 0 so CTRL, which starts the target, goes last.
                if (r_idx == 2'd0) begin
                    w_next = WAIT_DONE;
                end else begin
                    w_next     = SETUP;
                    w_next_idx = r_idx + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (operation_done || w_timeout_hit)
                    w_next = RESULT;
            end
            RESULT: begin
                if (res_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The first SETUP is registered on the accept edge, before the job fields are latched.
    always_comb begin
        w_wdata = '0;
        case (w_next_idx)
            2'd0: w_wdata = AMBA_WORD'(r_ctrl);
            2'd1: w_wdata = AMBA_WORD'((r_state == IDLE) ? job_data : r_data);
            2'd2: w_wdata = AMBA_WORD'(r_width);
            2'd3: w_wdata = AMBA_WORD'(r_noise);
            default: w_wdata = '0;
        endcase
        w_paddr = AMBA_ADDR_WIDTH'(BASE_ADDR) + AMBA_ADDR_WIDTH'({w_next_idx, 2'b00});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_data      <= '0;
            r_width     <= '0;
            r_noise     <= '0;
            r_cnt       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_errors  <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (r_state == IDLE && job_valid) begin
                r_ctrl  <= job_ctrl;
                r_data  <= job_data;
                r_width <= job_width;
                r_noise <= job_noise;
            end

            PSEL    <= (w_next == SETUP) || (w_next == ACCESS);
            PENABLE <= (w_next == ACCESS);
            PWRITE  <= (w_next == SETUP) || (w_next == ACCESS);
            if (w_next == SETUP) begin
                PADDR  <= w_paddr;
                PWDATA <= w_wdata;
            end

            if (r_state == ACCESS && w_next == WAIT_DONE)
                r_cnt <= '0;
            else if (r_state == WAIT_DONE && !operation_done && !w_timeout_hit)
                r_cnt <= r_cnt + 1'b1;

            if (r_state == WAIT_DONE) begin
                if (operation_done) begin
                    res_data    <= data_out;
                    res_errors  <= num_of_errors;
                    res_timeout <= 1'b0;
                end else if (w_timeout_hit) begin
                    res_data    <= '0;
                    res_errors  <= '0;
                    res_timeout <= 1'b1;
                end
            end

            res_valid <= (w_next == RESULT);
        end
    end

endmodule
